car_history_tracker: RTL
========================

Name: car_history_tracker

Overview:
- Parametrised successor to the single-lot 8x16 car tracker.
- Counts cars entering the lot and stores the cumulative count at each hour boundary in an internal HOURS x COUNT_W memory.
- Replays the stored history in a ping-pong sweep (0 up to HOURS-1, then back down to 0) for the display path.
- Adds count saturation, end-of-day lockout, a step-enable sweep (no internal clock divider), and a valid-qualified read output.

Parameters:
HOURS, 8, number of hour slots stored (>=2)
COUNT_W, 16, width of car counter and stored words
ADDR_W, $clog2(HOURS), width of hour and read addresses (derived, not overridden)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state
car_in  in  1  one car entered this cycle (single-cycle pulse)
hour_tick  in  1  hour boundary; commit count to memory this cycle
start  in  1  begin replay sweep (ignored while busy)
step  in  1  advance sweep one address (external rate enable, e.g. 1 Hz strobe)
car_count  out  COUNT_W  cumulative cars today
hour_count  out  ADDR_W  current hour slot
day_done  out  1  all HOURS slots written; tracking frozen
busy  out  1  sweep in progress
rd_addr  out  ADDR_W  address currently presented to memory
rd_data  out  COUNT_W  stored count for previous-cycle rd_addr
rd_valid  out  1  rd_data is valid sweep data

Behaviour:
- Reset (async, any time including mid-sweep): car_count=0, hour_count=0, day_done=0, state=IDLE, busy=0, rd_addr=0, rd_data=0, rd_valid=0.
- Memory contents are not cleared by reset. Reads of unwritten slots are "don't care" to the bench.
- Counting: if car_in && !day_done, car_count += 1, saturating at 2^COUNT_W-1 (no wrap).
- Commit: on hour_tick && !day_done, mem[hour_count] <= car_count_next, i.e. the value including any same-cycle car_in.
  - If hour_count < HOURS-1: hour_count += 1.
  - Else: hour_count holds and day_done <= 1.
  - After day_done, car_in and hour_tick are ignored until reset.
- Sweep FSM, states IDLE, UP, DOWN:
  - IDLE: rd_addr=0, busy=0. If start, go to UP with rd_addr=0 and busy=1.
  - UP: on step, if rd_addr==HOURS-1 go to DOWN with rd_addr=HOURS-2; else rd_addr+1.
  - DOWN: on step, if rd_addr==0 go to IDLE; else rd_addr-1.
  - Without step, state and rd_addr hold.
  - Full address sequence is 0,1,...,HOURS-1,HOURS-2,...,0 (2*HOURS-1 addresses); address 0 ends the sweep.
  - start while busy: no effect.
- Read latency: 1 cycle. rd_data <= mem[rd_addr] every cycle; rd_valid <= busy (registered).
- Read during same-cycle write to the same address returns old data; new data is visible the next cycle.
- Counting and commits continue independently of the sweep.

Decomposition:
- Package parking_pkg holds:
  - typedef enum logic [1:0] {IDLE, UP, DOWN} sweep_state_t
  - localparam helpers for saturation max.
- One sub-module: car_count_mem, a simple dual-port memory.
  - Parameters: DEPTH, WIDTH.
  - Write port: wren, wraddr, wdata.
  - Registered read port: rdaddr, q.
  - Old-data read-during-write; no reset on the array.

Test Plan:
1. Defaults. Reset; 3 car_in pulses; hour_tick -> mem[0]=3, hour_count=1, car_count=3.
2. Simultaneous events. car_in and hour_tick in the same cycle with car_count=3 -> mem[1]=4, car_count=4, hour_count=2.
3. End of day. Issue 8 hour_ticks -> day_done=1 after the 8th and hour_count=7. A further car_in and hour_tick change nothing.
4. Sweep. Memory filled with 0..7 (each slot = its index). Pulse start, then hold step=1 -> rd_addr sequence 0,1,...,7,6,...,0; rd_data follows one cycle later; busy falls after the final 0; 15 valid reads.
5. Step gating and start while busy. step asserted every 3rd cycle -> rd_addr changes only on those cycles. start pulsed mid-sweep -> sequence unaffected.
6. Async reset and saturation. Assert reset mid-edge during DOWN -> outputs zero immediately, IDLE. With COUNT_W=4, 20 car_in pulses -> car_count=15.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and defaults for the car history tracker.
package parking_pkg;

  typedef enum logic [1:0] {IDLE, UP, DOWN} sweep_state_t;

  localparam int unsigned DefaultHours  = 8;
  localparam int unsigned DefaultCountW = 16;

  // All-ones ceiling for a saturating counter of the given width (width <= 32).
  function automatic logic [31:0] sat_max(input int unsigned width);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/car_count_mem.sv
// Simple dual-port history memory: one write port, one registered read port with
// old-data read-during-write behaviour. The array itself is never reset.
module car_count_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wren,
  input  logic [AW-1:0]    wraddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    rdaddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wren) mem_q[wraddr] <= wdata;
  end

  // Only the output register is cleared so rd_data reads zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= '0;
    else       q <= mem_q[rdaddr];
  end

endmodule

// File: rtl/car_history_tracker.sv
// Counts cars, commits the running total at each hour boundary, and replays the
// stored history as a step-paced ping-pong sweep with a valid-qualified read.
module car_history_tracker
  import parking_pkg::*;
#(
  parameter int unsigned HOURS   = DefaultHours,
  parameter int unsigned COUNT_W = DefaultCountW,
  localparam int unsigned ADDR_W = $clog2(HOURS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               car_in,
  input  logic               hour_tick,
  input  logic               start,
  input  logic               step,
  output logic [COUNT_W-1:0] car_count,
  output logic [ADDR_W-1:0]  hour_count,
  output logic               day_done,
  output logic               busy,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid
);

  localparam logic [ADDR_W-1:0]  LastAddr    = ADDR_W'(HOURS - 1);
  localparam logic [ADDR_W-1:0]  PenultAddr  = ADDR_W'(HOURS - 2);
  localparam logic [COUNT_W-1:0] CountMax    = COUNT_W'(sat_max(COUNT_W));

  logic [COUNT_W-1:0] car_count_q, car_count_d;
  logic [ADDR_W-1:0]  hour_q, hour_d;
  logic               day_done_q, day_done_d;
  logic               commit;

  sweep_state_t       state_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               busy_q;
  logic               rd_valid_q;

  always_comb begin
    car_count_d = car_count_q;
    hour_d      = hour_q;
    day_done_d  = day_done_q;
    commit      = hour_tick && !day_done_q;
    if (car_in && !day_done_q && (car_count_q != CountMax)) begin
      car_count_d = car_count_q + COUNT_W'(1);
    end
    if (commit) begin
      if (hour_q == LastAddr) day_done_d = 1'b1;
      else                    hour_d     = hour_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      car_count_q <= '0;
      hour_q      <= '0;
      day_done_q  <= 1'b0;
    end else begin
      car_count_q <= car_count_d;
      hour_q      <= hour_d;
      day_done_q  <= day_done_d;
    end
  end

  // Sweep FSM: 0 up to HOURS-1, then back down; reaching 0 on the way down ends it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= busy_q;
      case (state_q)
        IDLE: begin
          rd_addr_q <= '0;
          if (start) begin
            state_q <= UP;
            busy_q  <= 1'b1;
          end
        end
        UP: begin
          if (step) begin
            if (rd_addr_q == LastAddr) begin
              state_q   <= DOWN;
              rd_addr_q <= PenultAddr;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end
        end
        DOWN: begin
          if (step) begin
            if (rd_addr_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              rd_addr_q <= rd_addr_q - ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          rd_addr_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  car_count_mem #(
    .DEPTH (HOURS),
    .WIDTH (COUNT_W)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .wren   (commit),
    .wraddr (hour_q),
    .wdata  (car_count_d),
    .rdaddr (rd_addr_q),
    .q      (rd_data)
  );

  assign car_count  = car_count_q;
  assign hour_count = hour_q;
  assign day_done   = day_done_q;
  assign busy       = busy_q;
  assign rd_addr    = rd_addr_q;
  assign rd_valid   = rd_valid_q;

endmodule
